// File: rtl/buffer_sched.sv
// Frame sequencer for the HOG cell delay buffer: drives shift/clear strobes,
// tracks raster position and hands completed WIN x WIN cells downstream.
module buffer_sched #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int WIN   = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             buf_shift,
  output logic             buf_clear,
  output logic             o_win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] o_cell_x,
  output logic [CNT_W-1:0] o_cell_y,
  output logic             busy,
  output logic             frame_done
);

  localparam int SH = $clog2(WIN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] col_r, col_s, row_r, row_s;
  logic [CNT_W-1:0] cell_x_r, cell_x_s, cell_y_r, cell_y_s;
  logic             win_valid_r, win_valid_s;
  logic             last_r, last_s;
  logic             accept_s, hs_s, col_end_s, row_end_s, cell_done_s;

  assign o_win_valid = win_valid_r;
  assign o_cell_x    = cell_x_r;
  assign o_cell_y    = cell_y_r;

  // Next-state, counter and strobe logic; abort overrides everything last.
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    row_s       = row_r;
    cell_x_s    = cell_x_r;
    cell_y_s    = cell_y_r;
    win_valid_s = win_valid_r;
    last_s      = last_r;
    i_ready     = 1'b0;
    buf_shift   = 1'b0;
    buf_clear   = 1'b0;
    frame_done  = 1'b0;
    accept_s    = 1'b0;
    busy        = (state_r != S_IDLE);
    hs_s        = win_valid_r && win_ready;
    col_end_s   = (col_r == CNT_W'(IMG_W - 1));
    row_end_s   = (row_r == CNT_W'(IMG_H - 1));
    cell_done_s = ((col_r & CNT_W'(WIN - 1)) == CNT_W'(WIN - 1)) &&
                  ((row_r & CNT_W'(WIN - 1)) == CNT_W'(WIN - 1));

    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_CLEAR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        buf_clear = 1'b1;
        col_s     = '0;
        row_s     = '0;
        last_s    = 1'b0;
        state_s   = S_RUN;
      end
      S_RUN: begin
        // A stalled cell blocks pixels; the handshake cycle itself may accept one.
        i_ready   = !last_r && !(win_valid_r && !win_ready);
        accept_s  = i_valid && i_ready;
        buf_shift = accept_s;
        if (hs_s) begin
          win_valid_s = 1'b0;
        end else begin
          win_valid_s = win_valid_r;
        end
        if (accept_s) begin
          if (col_end_s) begin
            col_s = '0;
            if (row_end_s) begin
              row_s  = '0;
              last_s = 1'b1;
            end else begin
              row_s = row_r + CNT_W'(1);
            end
          end else begin
            col_s = col_r + CNT_W'(1);
          end
          if (cell_done_s) begin
            win_valid_s = 1'b1;
            cell_x_s    = CNT_W'(col_r >> SH);
            cell_y_s    = CNT_W'(row_r >> SH);
          end else begin
            cell_x_s = cell_x_r;
          end
        end else begin
          col_s = col_r;
        end
        if (last_r && (!win_valid_r || win_ready)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_s    = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (abort && (state_r != S_IDLE)) begin
      state_s     = S_IDLE;
      col_s       = '0;
      row_s       = '0;
      cell_x_s    = '0;
      cell_y_s    = '0;
      win_valid_s = 1'b0;
      last_s      = 1'b0;
      buf_clear   = 1'b1;
    end else begin
      last_s = last_s;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      col_r       <= '0;
      row_r       <= '0;
      cell_x_r    <= '0;
      cell_y_r    <= '0;
      win_valid_r <= 1'b0;
      last_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_r       <= col_s;
      row_r       <= row_s;
      cell_x_r    <= cell_x_s;
      cell_y_r    <= cell_y_s;
      win_valid_r <= win_valid_s;
      last_r      <= last_s;
    end
  end

endmodule

// File: doc/buffer_sched.md
Name: buffer_sched

Overview:
Frame-level sequencer for the cell delay buffer in the HOG pipeline.
- Accepts a raster pixel stream and issues shift-enable and clear strobes to the buffer.
- Tracks column and row position within the frame.
- Flags each completed WIN x WIN cell to the downstream histogram stage, with backpressure.
- Sits between the pixel source and the buffer / HOG-cell logic; one instance per frame stream.

Parameters:
IMG_W, 160, frame width in pixels (>= 2*WIN, multiple of WIN)
IMG_H, 120, frame height in pixels (>= WIN, multiple of WIN)
WIN, 8, cell edge in pixels; power of 2, >= 2
CNT_W, 8, counter width; 2^CNT_W >= max(IMG_W, IMG_H)

Ports:
clk  input  1  the clock
rst  input  1  reset; asynchronous, active-low
start  input  1  begin a frame; sampled only in IDLE
abort  input  1  terminate frame; takes effect from any non-IDLE state
i_valid  input  1  pixel present on upstream stream
i_ready  output  1  controller can accept a pixel this cycle
buf_shift  output  1  shift-enable to buffer (drives its i_valid)
buf_clear  output  1  clear strobe to buffer counter
o_win_valid  output  1  a completed cell is available
win_ready  input  1  downstream accepts cell
o_cell_x  output  CNT_W  cell column index (col/WIN) of the flagged cell
o_cell_y  output  CNT_W  cell row index (row/WIN) of the flagged cell
busy  output  1  high in CLEAR, RUN, DONE
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst=0, async): state=IDLE, col=row=0. All outputs 0: i_ready, buf_shift, buf_clear, o_win_valid, o_cell_x, o_cell_y, busy, frame_done.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE
  - i_ready=0.
  - start=1 -> CLEAR.
- CLEAR (exactly 1 cycle)
  - buf_clear=1; col and row zeroed.
  - Next state RUN.
- RUN
  - i_ready = !(o_win_valid && !win_ready). Combinational, so a cell handshake and a pixel accept can occur in the same cycle.
  - Accept = i_valid && i_ready.
  - buf_shift = accept (combinational, same cycle); buf_shift is 0 in all other states.
  - On accept: col++. At col==IMG_W-1: col wraps to 0 and row++.
- Cell completion
  - Condition: accept with (col mod WIN)==WIN-1 and (row mod WIN)==WIN-1.
  - Response: o_win_valid registered high on the next cycle, with o_cell_x=col/WIN and o_cell_y=row/WIN of the pixel just accepted.
  - o_win_valid and the cell indices hold stable until a cycle with o_win_valid && win_ready; o_win_valid then clears on the next edge.
  - Cells are at least WIN>=2 accepts apart, so a new cell can never coincide with a pending unaccepted one.
- End of frame
  - Accept at col==IMG_W-1, row==IMG_H-1: col and row return to 0; no further pixels accepted (i_ready=0).
  - Stay in RUN until the final cell handshake completes, then -> DONE.
- DONE (1 cycle): frame_done=1 -> IDLE.
- abort=1 in CLEAR, RUN or DONE:
  - Next state IDLE; o_win_valid dropped; counters zeroed; buf_clear=1 for that cycle.
  - A pending cell is discarded.
  - If abort coincides with an accept, the accept still occurs (buf_shift=1), but counters are zeroed.
- start outside IDLE: ignored. start together with abort: abort wins.
- busy = (state != IDLE), combinational.
- Counters are unsigned, CNT_W bits, with no overflow beyond IMG_W-1 / IMG_H-1.

Test Plan:
Bench configuration: IMG_W=16, IMG_H=16, WIN=8, CNT_W=8.
1. Reset: rst low mid-RUN with o_win_valid=1 -> all outputs 0 immediately and state IDLE; after release, i_ready=0 until start.
2. start pulse, i_valid always 1, win_ready always 1 -> buf_clear high 1 cycle; then 256 buf_shift pulses; o_win_valid at accepts 119, 127, 247, 255 with (x,y) = (0,0), (1,0), (0,1), (1,1); frame_done 1 cycle after final handshake; busy low after.
3. Backpressure: win_ready=0 for 5 cycles after cell (0,0) -> i_ready=0, no buf_shift, cell indices stable for those cycles; win_ready=1 -> pixel accepted that same cycle.
4. Gappy input: i_valid toggling 1,0,1,0 -> col advances only on accepts; cells still flagged at accepts 119/127/247/255.
5. abort at accept 130 while o_win_valid pending -> o_win_valid drops, buf_clear=1 that cycle, state IDLE; new start yields cell (0,0) again at accept 119.
6. start asserted during RUN -> no effect; start with abort in RUN -> IDLE, no CLEAR entry.
